// File: rtl/sound_scheduler_if.sv
// Handshake/bus bundle between the game logic and the sound scheduler.
// The master drives event inputs; the slave (scheduler) drives tone outputs.
interface sound_scheduler_if;
  logic       button_i;
  logic       goodColl_i;
  logic       badColl_i;
  logic [3:0] direction_i;
  logic       tone_en_o;
  logic [1:0] tone_sel_o;
  logic [7:0] tone_per_o;
  logic       mute_o;
  logic       busy_o;

  modport master (
    output button_i, goodColl_i, badColl_i, direction_i,
    input  tone_en_o, tone_sel_o, tone_per_o, mute_o, busy_o
  );

  modport slave (
    input  button_i, goodColl_i, badColl_i, direction_i,
    output tone_en_o, tone_sel_o, tone_per_o, mute_o, busy_o
  );
endinterface

// File: rtl/sound_scheduler.sv
// Arbitrates game sound events onto the single tone datapath: fixed-priority
// pending requests, timed tones with a silent gap, preemption and mute toggle.
//
// state  | meaning
// IDLE   | nothing playing, waiting for a pending request
// PLAY   | tone on, counter runs down the tone duration
// GAP    | tone off, counter runs down the silent gap
module sound_scheduler #(
  parameter logic [15:0] BAD_CYC  = 16'd2000,
  parameter logic [15:0] GOOD_CYC = 16'd1500,
  parameter logic [15:0] MOVE_CYC = 16'd500,
  parameter logic [15:0] GAP_CYC  = 16'd100,
  parameter logic [7:0]  BAD_PER  = 8'd200,
  parameter logic [7:0]  GOOD_PER = 8'd60,
  parameter logic [7:0]  MOVE_PER = 8'd120
) (
  input  logic               clk,
  input  logic               nRst,
  sound_scheduler_if.slave   sch_if
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  // Selector codes double as priority rank: larger code wins.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MOVE = 2'b01;
  localparam logic [1:0] SEL_GOOD = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  per_q, per_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        mute_q, mute_d;
  logic        btn_prev_q, good_prev_q, bad_prev_q;
  logic [3:0]  dir_prev_q;

  logic       btn_rise, good_rise, bad_rise, move_req, mute_on, launch;
  logic [2:0] req, launch_mask;
  logic [1:0] best_sel;

  function automatic logic [15:0] dur_m1(input logic [1:0] sel);
    case (sel)
      SEL_BAD:  dur_m1 = BAD_CYC - 16'd1;
      SEL_GOOD: dur_m1 = GOOD_CYC - 16'd1;
      SEL_MOVE: dur_m1 = MOVE_CYC - 16'd1;
      default:  dur_m1 = 16'd0;
    endcase
  endfunction

  function automatic logic [7:0] per_of(input logic [1:0] sel);
    case (sel)
      SEL_BAD:  per_of = BAD_PER;
      SEL_GOOD: per_of = GOOD_PER;
      SEL_MOVE: per_of = MOVE_PER;
      default:  per_of = 8'd0;
    endcase
  endfunction

  always_comb begin
    btn_rise  = sch_if.button_i & ~btn_prev_q;
    good_rise = sch_if.goodColl_i & ~good_prev_q;
    bad_rise  = sch_if.badColl_i & ~bad_prev_q;
    move_req  = (sch_if.direction_i != 4'd0) && (sch_if.direction_i != dir_prev_q);
    mute_on   = btn_rise & ~mute_q;
    mute_d    = mute_q ^ btn_rise;
    // Requests are accepted only when the post-edge mute state is off.
    req       = mute_d ? 3'b000 : {bad_rise, good_rise, move_req};

    if (pend_q[2])      best_sel = SEL_BAD;
    else if (pend_q[1]) best_sel = SEL_GOOD;
    else if (pend_q[0]) best_sel = SEL_MOVE;
    else                best_sel = SEL_NONE;

    launch  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;

    case (state_q)
      S_IDLE: begin
        if (best_sel != SEL_NONE) launch = 1'b1;
      end
      S_PLAY: begin
        if (best_sel > sel_q) begin
          launch = 1'b1;
        end else if (cnt_q == 16'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_CYC - 16'd1;
          sel_d   = SEL_NONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q != 16'd0)              cnt_d = cnt_q - 16'd1;
        else if (best_sel != SEL_NONE)   launch = 1'b1;
        else                             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    launch_mask = 3'b000;
    if (launch) begin
      state_d     = S_PLAY;
      sel_d       = best_sel;
      cnt_d       = dur_m1(best_sel);
      launch_mask = {best_sel == SEL_BAD, best_sel == SEL_GOOD, best_sel == SEL_MOVE};
    end

    pend_d = (pend_q & ~launch_mask) | req;

    if (mute_on) begin
      state_d = S_IDLE;
      pend_d  = 3'b000;
      sel_d   = SEL_NONE;
      cnt_d   = 16'd0;
    end

    en_d   = (state_d == S_PLAY);
    per_d  = en_d ? per_of(sel_d) : 8'd0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      pend_q      <= 3'b000;
      sel_q       <= SEL_NONE;
      per_q       <= 8'd0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      mute_q      <= 1'b0;
      btn_prev_q  <= 1'b0;
      good_prev_q <= 1'b0;
      bad_prev_q  <= 1'b0;
      dir_prev_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      sel_q       <= sel_d;
      per_q       <= per_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      mute_q      <= mute_d;
      btn_prev_q  <= sch_if.button_i;
      good_prev_q <= sch_if.goodColl_i;
      bad_prev_q  <= sch_if.badColl_i;
      dir_prev_q  <= sch_if.direction_i;
    end
  end

  assign sch_if.tone_en_o  = en_q;
  assign sch_if.tone_sel_o = sel_q;
  assign sch_if.tone_per_o = per_q;
  assign sch_if.mute_o     = mute_q;
  assign sch_if.busy_o     = busy_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench: stimulus pushes the hand-computed per-cycle output vector,
// a monitor pops one entry after every rising edge and compares.
module tb_sound_scheduler;
  logic clk = 1'b0;
  logic nRst;

  sound_scheduler_if bus ();

  sound_scheduler #(
    .BAD_CYC(16'd12), .GOOD_CYC(16'd8), .MOVE_CYC(16'd4), .GAP_CYC(16'd2),
    .BAD_PER(8'd200), .GOOD_PER(8'd60), .MOVE_PER(8'd120)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .sch_if(bus)
  );

  always #5 clk = ~clk;

  // vector = {en, sel[1:0], per[7:0], mute, busy}
  typedef struct {
    logic [12:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  task automatic cyc(input int n, input logic en, input logic [1:0] sel,
                     input logic [7:0] per, input logic mute, input logic busy,
                     input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v   = {en, sel, per, mute, busy};
      e.tag = $sformatf("%s[%0d]", tag, i);
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n, input string tag); cyc(n, 1'b0, 2'b00, 8'd0,   1'b0, 1'b0, tag); endtask
  task automatic gap (input int n, input string tag); cyc(n, 1'b0, 2'b00, 8'd0,   1'b0, 1'b1, tag); endtask
  task automatic mut (input int n, input string tag); cyc(n, 1'b0, 2'b00, 8'd0,   1'b1, 1'b0, tag); endtask
  task automatic bad (input int n, input string tag); cyc(n, 1'b1, 2'b11, 8'd200, 1'b0, 1'b1, tag); endtask
  task automatic good(input int n, input string tag); cyc(n, 1'b1, 2'b10, 8'd60,  1'b0, 1'b1, tag); endtask
  task automatic move(input int n, input string tag); cyc(n, 1'b1, 2'b01, 8'd120, 1'b0, 1'b1, tag); endtask

  // Monitor: one comparison per clock while expectations are queued.
  initial begin
    exp_t        e;
    logic [12:0] act;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {bus.tone_en_o, bus.tone_sel_o, bus.tone_per_o, bus.mute_o, bus.busy_o};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got en=%b sel=%b per=%0d mute=%b busy=%b, expected en=%b sel=%b per=%0d mute=%b busy=%b",
                   e.tag, act[12], act[11:10], act[9:2], act[1], act[0],
                   e.v[12], e.v[11:10], e.v[9:2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    // 1: reset with every input high, then release with goodColl held high
    nRst = 1'b0;
    bus.button_i = 1'b1; bus.goodColl_i = 1'b1; bus.badColl_i = 1'b1; bus.direction_i = 4'hF;
    idle(2, "s1_reset");
    bus.button_i = 1'b0; bus.badColl_i = 1'b0; bus.direction_i = 4'h0; nRst = 1'b1;
    idle(1, "s1_pend");
    good(8, "s1_good");
    gap(2, "s1_gap");
    idle(2, "s1_idle");

    // 2: single goodColl edge from IDLE
    bus.goodColl_i = 1'b0;
    idle(1, "s2_low");
    bus.goodColl_i = 1'b1;
    idle(1, "s2_pend");
    good(8, "s2_good");
    gap(2, "s2_gap");
    idle(2, "s2_idle");
    bus.goodColl_i = 1'b0;

    // 3: MOVE preempted by BAD, no gap, MOVE dropped
    bus.direction_i = 4'b0001;
    idle(1, "s3_pend");
    move(2, "s3_move");
    bus.badColl_i = 1'b1;
    move(1, "s3_move_tail");
    bad(12, "s3_bad");
    gap(2, "s3_gap");
    idle(2, "s3_idle");
    bus.badColl_i = 1'b0;

    // 4: GOOD and direction change together -> GOOD, gap, MOVE, gap
    bus.goodColl_i = 1'b1; bus.direction_i = 4'b0100;
    idle(1, "s4_pend");
    good(8, "s4_good");
    gap(2, "s4_gap1");
    move(4, "s4_move");
    gap(2, "s4_gap2");
    idle(2, "s4_idle");
    bus.goodColl_i = 1'b0;

    // 5: mute during BAD; coincident GOOD edge dropped; BAD while muted ignored
    bus.badColl_i = 1'b1;
    idle(1, "s5_pend");
    bad(3, "s5_bad");
    bus.button_i = 1'b1; bus.goodColl_i = 1'b1;
    mut(1, "s5_mute_on");
    bus.button_i = 1'b0; bus.badColl_i = 1'b0;
    mut(1, "s5_muted");
    bus.badColl_i = 1'b1;
    mut(4, "s5_bad_muted");
    bus.goodColl_i = 1'b0; bus.badColl_i = 1'b0;
    mut(1, "s5_muted2");
    bus.button_i = 1'b1;
    idle(1, "s5_unmute");
    bus.button_i = 1'b0;
    idle(3, "s5_idle");

    // 6: reset mid-PLAY clears outputs and pending, then a fresh request
    bus.goodColl_i = 1'b1;
    idle(1, "s6_pend");
    good(3, "s6_good");
    bus.direction_i = 4'b1000;
    nRst = 1'b0;
    idle(1, "s6_reset");
    bus.goodColl_i = 1'b0; bus.direction_i = 4'h0; nRst = 1'b1;
    idle(2, "s6_cleared");
    bus.goodColl_i = 1'b1;
    idle(1, "s6_pend2");
    good(8, "s6_good2");
    gap(2, "s6_gap");
    idle(2, "s6_idle");

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    if (!done) begin
      $display("FAIL timeout: got no completion by 50000, expected completion");
      $fatal(1, "timeout");
    end
  end
endmodule
